// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_C = 32'h0040_0000;
    localparam logic [31:0] PC_STEP_C  = 32'd4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register that catches an instruction
// returned while the IF/ID consumer is stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        full_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        full_q,  full_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;

    // Clear beats load so a redirect always wins over a same-cycle capture.
    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            full_d  = 1'b0;
            pc_d    = 32'h0;
            instr_d = NOP_INSTR;
        end else if (load_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (unload_i) begin
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            full_q  <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem req/ack
// handshake and delivers {pc, pc+4, instr, valid} to the IF/ID boundary.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_C,
    parameter logic [31:0] PC_STEP  = PC_STEP_C
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic         vld_q, vld_d;
    logic [31:0]  opc_q, opc_d;
    logic [31:0]  opc4_q, opc4_d;
    logic [31:0]  oinstr_q, oinstr_d;

    logic         skid_load, skid_unload, skid_clear, skid_full;
    logic [31:0]  skid_pc, skid_instr;
    logic [31:0]  pc_plus;

    assign pc_plus = pc_q + PC_STEP;

    fetch_skid_buffer u_skid (
        .clock_i  (clock),
        .reset_ni (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .pc_i     (pc_q),
        .instr_i  (imem_rdata),
        .full_o   (skid_full),
        .pc_o     (skid_pc),
        .instr_o  (skid_instr)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (!imem_ack) state_d = ST_DRAIN;
                end else if (imem_ack && stall && vld_q) begin
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: if (imem_ack) state_d = ST_FETCH;
            ST_HOLD:  if (redirect_valid || !stall) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // An un-stalled consumer takes the payload, so valid falls unless reloaded.
    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        vld_d       = stall ? vld_q : 1'b0;
        opc_d       = opc_q;
        opc4_d      = opc4_q;
        oinstr_d    = oinstr_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        imem_req    = (state_q != ST_HOLD);
        imem_addr   = pc_q;
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    vld_d = 1'b0;
                    if (imem_ack) pc_d   = redirect_pc;
                    else          pend_d = redirect_pc;
                end else if (imem_ack) begin
                    pc_d = pc_plus;
                    if (!stall || !vld_q) begin
                        vld_d    = 1'b1;
                        opc_d    = pc_q;
                        opc4_d   = pc_plus;
                        oinstr_d = imem_rdata;
                    end else begin
                        skid_load = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                vld_d = 1'b0;
                if (redirect_valid) begin
                    if (imem_ack) pc_d   = redirect_pc;
                    else          pend_d = redirect_pc;
                end else if (imem_ack) begin
                    pc_d = pend_q;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    vld_d      = 1'b0;
                    skid_clear = 1'b1;
                    pc_d       = redirect_pc;
                end else if (!stall) begin
                    vld_d       = skid_full;
                    opc_d       = skid_pc;
                    opc4_d      = skid_pc + PC_STEP;
                    oinstr_d    = skid_instr;
                    skid_unload = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            vld_q    <= 1'b0;
            opc_q    <= 32'h0;
            opc4_q   <= 32'h0;
            oinstr_q <= NOP_INSTR;
        end else begin
            pc_q     <= pc_d;
            vld_q    <= vld_d;
            opc_q    <= opc_d;
            opc4_q   <= opc4_d;
            oinstr_q <= oinstr_d;
        end
    end

    // The pending target is only read in DRAIN, which always writes it first.
    always_ff @(posedge clock) begin
        pend_q <= pend_d;
    end

    assign if_valid    = vld_q;
    assign if_pc       = opc_q;
    assign if_pc_plus4 = opc4_q;
    assign if_instr    = oinstr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a latency-programmable imem model.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;

    int n_tests = 0;
    int n_fail  = 0;

    int lat        = 0;
    int ack_budget = 0;
    int wait_cnt   = 0;
    int acks_taken = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;
    exp_t sb_q[$];

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: ack after `lat` waiting cycles, at most `ack_budget` acks.
    assign imem_ack   = imem_req && (acks_taken < ack_budget) && (wait_cnt >= lat);
    assign imem_rdata = imem_ack ? imem_word(imem_addr) : 32'h0;

    always @(posedge clock) begin
        if (!reset) begin
            wait_cnt   <= 0;
            acks_taken <= 0;
        end else if (imem_ack) begin
            wait_cnt   <= 0;
            acks_taken <= acks_taken + 1;
        end else if (imem_req) begin
            wait_cnt   <= wait_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: a payload is consumed on any cycle it is valid and not stalled.
    always @(negedge clock) begin
        if (reset && if_valid && !stall) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_instr actual_pc=%h required=none", if_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("if_pc", if_pc, e.pc);
                check("if_pc_plus4", if_pc_plus4, e.pc4);
                check("if_instr", if_instr, e.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.pc    = pc;
        e.pc4   = pc4;
        e.instr = imem_word(pc);
        sb_q.push_back(e);
    endtask

    task automatic do_reset(input int l, input int b);
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        lat            = l;
        ack_budget     = b;
        tick();
        tick();
    endtask

    task automatic drain(input string name);
        int i = 0;
        while (sb_q.size() != 0 && i < 60) begin
            tick();
            i++;
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain actual_remaining=%0d required=0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (4) tick();
    endtask

    initial begin
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state and zero-wait back-to-back fetch
        do_reset(0, 3);
        sample();
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_pc_plus4", if_pc_plus4, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        tick();
        expect_instr(32'h0040_0000, 32'h0040_0004);
        expect_instr(32'h0040_0004, 32'h0040_0008);
        expect_instr(32'h0040_0008, 32'h0040_000C);
        reset = 1'b1;
        sample();
        check("zw_req_c1", {31'b0, imem_req}, 32'h1);
        check("zw_addr_c1", imem_addr, 32'h0040_0000);
        tick();
        sample();
        check("zw_addr_c2", imem_addr, 32'h0040_0004);
        tick();
        sample();
        check("zw_addr_c3", imem_addr, 32'h0040_0008);
        check("zw_valid_c3", {31'b0, if_valid}, 32'h1);
        drain("zero_wait");

        // Two-cycle ack latency
        do_reset(1, 2);
        expect_instr(32'h0040_0000, 32'h0040_0004);
        expect_instr(32'h0040_0004, 32'h0040_0008);
        reset = 1'b1;
        sample();
        check("lat_addr_c1", imem_addr, 32'h0040_0000);
        tick();
        sample();
        check("lat_addr_c2", imem_addr, 32'h0040_0000);
        tick();
        sample();
        check("lat_addr_c3", imem_addr, 32'h0040_0004);
        check("lat_valid_c3", {31'b0, if_valid}, 32'h1);
        drain("latency");

        // Ack under stall lands in the skid buffer
        do_reset(0, 3);
        expect_instr(32'h0040_0000, 32'h0040_0004);
        expect_instr(32'h0040_0004, 32'h0040_0008);
        expect_instr(32'h0040_0008, 32'h0040_000C);
        reset = 1'b1;
        tick();
        stall = 1'b1;
        tick();
        sample();
        check("skid_req_hold", {31'b0, imem_req}, 32'h0);
        check("skid_if_pc_hold", if_pc, 32'h0040_0000);
        check("skid_valid_hold", {31'b0, if_valid}, 32'h1);
        tick();
        tick();
        stall = 1'b0;
        tick();
        sample();
        check("skid_resume_addr", imem_addr, 32'h0040_0008);
        check("skid_if_pc_next", if_pc, 32'h0040_0004);
        drain("skid");

        // Redirect while a slow request is outstanding
        do_reset(2, 4);
        expect_instr(32'h0040_0000, 32'h0040_0004);
        expect_instr(32'h0040_0004, 32'h0040_0008);
        expect_instr(32'h0040_0100, 32'h0040_0104);
        reset = 1'b1;
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0100;
        tick();
        redirect_valid = 1'b0;
        sample();
        check("drain_addr_stable", imem_addr, 32'h0040_0008);
        check("drain_valid", {31'b0, if_valid}, 32'h0);
        tick();
        tick();
        sample();
        check("drain_new_addr", imem_addr, 32'h0040_0100);
        check("drain_valid_after", {31'b0, if_valid}, 32'h0);
        drain("redirect_drain");

        // Redirect and stall together with a full skid buffer
        do_reset(0, 4);
        expect_instr(32'h0040_0200, 32'h0040_0204);
        expect_instr(32'h0040_0204, 32'h0040_0208);
        reset = 1'b1;
        tick();
        stall = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0200;
        sample();
        check("rs_req_in_hold", {31'b0, imem_req}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        sample();
        check("rs_valid_cleared", {31'b0, if_valid}, 32'h0);
        check("rs_addr_target", imem_addr, 32'h0040_0200);
        drain("redirect_stall");

        // PC wrap at the top of the address space
        do_reset(0, 3);
        expect_instr(32'hFFFF_FFFC, 32'h0000_0000);
        expect_instr(32'h0000_0000, 32'h0000_0004);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        sample();
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        sample();
        check("wrap_addr_zero", imem_addr, 32'h0000_0000);
        drain("wrap");

        // Reset mid-wait with a late ack arriving during reset
        do_reset(5, 1);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        lat   = 2;
        tick();
        sample();
        check("mrst_valid", {31'b0, if_valid}, 32'h0);
        check("mrst_if_pc", if_pc, 32'h0);
        check("mrst_if_pc_plus4", if_pc_plus4, 32'h0);
        check("mrst_if_instr", if_instr, 32'h0);
        check("mrst_addr", imem_addr, 32'h0040_0000);
        tick();
        lat = 0;
        expect_instr(32'h0040_0000, 32'h0040_0004);
        reset = 1'b1;
        drain("mid_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
